// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch redirect sequencer.
package fetch_pkg;

    localparam int unsigned PC_W       = 32;
    localparam int unsigned PAIR_BYTES = 8;
    localparam int unsigned PAIR_SHIFT = 3;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
    localparam logic [PC_W-1:0] EXC_PC_DEFAULT   = 32'hbfc0_0380;

    typedef enum logic {
        RUN     = 1'b0,
        JR_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Request/control bundle between the pipeline and the fetch redirect sequencer.
interface fetch_redirect_ctrl_if;
    import fetch_pkg::*;

    logic            stall_hard;
    logic            stall_soft;
    logic            exc_req;
    logic            eret_req;
    logic [PC_W-1:0] cp0_epc;
    logic            br_req;
    logic [PC_W-1:0] br_target;
    logic            jr_req;
    logic [PC_W-1:0] jr_data;
    logic            jr_data_ok;
    logic            br_slot;
    logic [PC_W-1:0] pc;
    logic            fetch_en;
    logic            id_hold;
    logic            id_flush;
    logic            slot1_kill;
    logic            slot2_kill;
    logic            br_ack;

    modport master (
        output stall_hard, stall_soft, exc_req, eret_req, cp0_epc,
               br_req, br_target, jr_req, jr_data, jr_data_ok, br_slot,
        input  pc, fetch_en, id_hold, id_flush, slot1_kill, slot2_kill, br_ack
    );

    modport slave (
        input  stall_hard, stall_soft, exc_req, eret_req, cp0_epc,
               br_req, br_target, jr_req, jr_data, jr_data_ok, br_slot,
        output pc, fetch_en, id_hold, id_flush, slot1_kill, slot2_kill, br_ack
    );

endinterface

// File: rtl/fetch_redirect_ctrl_target_align.sv
// Aligns a redirect target to its 8-byte pair; bit 2 says slot 1 must be squashed.
module fetch_target_align
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pair_addr,
    output logic            slot1_kill
);

    assign pair_addr  = {target[PC_W-1:PAIR_SHIFT], PAIR_SHIFT'(0)};
    assign slot1_kill = target[2];

    // Byte offset within a word never affects which pair is fetched.
    logic unused_low;
    assign unused_low = ^target[1:0];

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer and IF->ID pair control; eret support enabled by FETCH_ERET_EN.
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [PC_W-1:0] EXC_PC   = EXC_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_redirect_ctrl_if.slave  bus
);

    fetch_state_e    state_q, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic            slot1_kill_q, slot1_kill_nxt;
    logic            slot_lat_q, slot_lat_nxt;

    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] tgt_pair;
    logic            tgt_kill;
    logic            redir;
    logic            hold;
    logic            eret_c;
    logic [PC_W-1:0] pc_seq;

`ifdef FETCH_ERET_EN
    assign eret_c = bus.eret_req;
`else
    // Ports stay on the interface but have no effect in this build.
    logic unused_eret;
    assign unused_eret = bus.eret_req ^ (^bus.cp0_epc);
    assign eret_c      = 1'b0;
`endif

    assign pc_seq = pc_q + PC_W'(PAIR_BYTES);

    fetch_target_align u_align (
        .target     (tgt),
        .pair_addr  (tgt_pair),
        .slot1_kill (tgt_kill)
    );

    // State, PC and slot-1 kill registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            slot1_kill_q <= 1'b0;
            slot_lat_q   <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            pc_q         <= pc_nxt;
            slot1_kill_q <= slot1_kill_nxt;
            slot_lat_q   <= slot_lat_nxt;
        end
    end

    // Redirect arbitration and next state.
    always_comb begin
        state_nxt    = state_q;
        slot_lat_nxt = slot_lat_q;
        tgt          = bus.br_target;
        redir        = 1'b0;
        hold         = 1'b0;
        if (bus.exc_req) begin
            tgt       = EXC_PC;
            redir     = 1'b1;
            state_nxt = RUN;
        end else if (eret_c) begin
            tgt       = bus.cp0_epc;
            redir     = 1'b1;
            state_nxt = RUN;
        end else if (bus.stall_hard) begin
            hold = 1'b1;
        end else if (state_q == JR_WAIT) begin
            if (bus.jr_data_ok) begin
                tgt       = bus.jr_data;
                redir     = 1'b1;
                state_nxt = RUN;
            end else begin
                hold = 1'b1;
            end
        end else if (bus.br_req) begin
            redir = 1'b1;
        end else if (bus.jr_req) begin
            if (bus.jr_data_ok) begin
                tgt   = bus.jr_data;
                redir = 1'b1;
            end else begin
                hold         = 1'b1;
                state_nxt    = JR_WAIT;
                slot_lat_nxt = bus.br_slot;
            end
        end else if (bus.stall_soft) begin
            hold = 1'b1;
        end

        if (redir) begin
            pc_nxt         = tgt_pair;
            slot1_kill_nxt = tgt_kill;
        end else if (hold) begin
            pc_nxt         = pc_q;
            slot1_kill_nxt = slot1_kill_q;
        end else begin
            pc_nxt         = pc_seq;
            slot1_kill_nxt = 1'b0;
        end
    end

    // ID-stage controls, combinational from state and current requests.
    always_comb begin
        bus.fetch_en   = reset;
        bus.id_hold    = 1'b0;
        bus.id_flush   = 1'b0;
        bus.slot2_kill = 1'b0;
        bus.br_ack     = 1'b0;
        if (reset) begin
            if (bus.exc_req || eret_c) begin
                bus.id_flush = 1'b1;
            end else if (bus.stall_hard) begin
                bus.id_hold = 1'b1;
            end else if (state_q == JR_WAIT) begin
                if (bus.jr_data_ok) begin
                    bus.br_ack     = 1'b1;
                    bus.slot2_kill = slot_lat_q;
                    bus.id_flush   = !slot_lat_q;
                end else begin
                    bus.id_hold = 1'b1;
                end
            end else if (bus.br_req || (bus.jr_req && bus.jr_data_ok)) begin
                bus.br_ack     = 1'b1;
                bus.slot2_kill = bus.br_slot;
                bus.id_flush   = !bus.br_slot;
            end else if (bus.jr_req) begin
                bus.id_hold = 1'b1;
            end else if (bus.stall_soft) begin
                bus.id_flush = 1'b1;
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.slot1_kill = slot1_kill_q;

endmodule
